mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 64: memory word width in bits.
REQ-002 Parameter DATA_BYTES, default DATA_WIDTH/8: byte lanes per word.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  pipeline load/store request valid.
REQ-006 req_ready  out  1  LSU can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  64  byte address.
REQ-011 req_wdata  in  64  store data, right-justified.
REQ-012 resp_valid  out  1  response available.
REQ-013 resp_ready  in  1  pipeline consumes response.
REQ-014 resp_rdata  out  64  extended load data; 0 for stores and faults.
REQ-015 resp_misalign  out  1  request was misaligned; no memory access made.
REQ-016 mem_addr  out  64  to data memory address input.
REQ-017 mem_wdata  out  64  to data memory write data, lane-aligned.
REQ-018 mem_wen  out  8  to data memory per-byte write enable; all zero = read.
REQ-019 mem_rdata  in  64  from data memory; valid one cycle after address is sampled.

Function
REQ-020 States IDLE, LOAD, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept = req_valid & req_ready at a rising edge; address, size, unsigned and byte offset (req_addr[2:0]) SHALL be latched on accept.
REQ-022 Misaligned = address not a multiple of 2^req_size; a byte access is never misaligned.
REQ-023 In IDLE, mem_addr SHALL equal req_addr combinationally; in LOAD/RESP, mem_addr SHALL equal the latched address.
REQ-024 mem_wen SHALL be nonzero only in IDLE with req_valid=1, req_we=1, aligned: 2^size consecutive bits set starting at bit req_addr[2:0].
REQ-025 mem_wdata SHALL equal req_wdata shifted left by 8*req_addr[2:0] bits, truncated to 64.
REQ-026 Aligned load accept: IDLE->LOAD; in LOAD, data SHALL be extracted from mem_rdata at bit 8*offset, width 8<<size, extended per req_unsigned, and registered into resp_rdata; LOAD->RESP unconditionally.
REQ-027 Aligned store accept: IDLE->RESP with resp_rdata=0, resp_misalign=0.
REQ-028 Misaligned accept (load or store): IDLE->RESP with resp_misalign=1, resp_rdata=0, mem_wen=0 throughout.
REQ-029 resp_valid SHALL be 1 exactly in RESP; resp_rdata and resp_misalign SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-030 RESP with resp_ready=1 SHALL go to IDLE; a new request SHALL not be accepted in the same cycle.
REQ-031 Latency: load response 2 cycles after accept, store/fault 1 cycle after accept, with resp_ready tied high.
REQ-032 Double-word load (size 3) SHALL return mem_rdata unchanged; extension is a no-op.
REQ-033 req_valid deasserted in IDLE SHALL produce mem_wen=0 and no state change.

Reset
REQ-034 While rst_n=0: state=IDLE, resp_valid=0, resp_rdata=0, resp_misalign=0, latched fields=0, mem_wen=0.
REQ-035 Reset assertion mid-LOAD or mid-RESP SHALL drop the pending response immediately; it is never presented after reset release.
REQ-036 First accept SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-037 Store SD addr 0x100 data 0x1122334455667788, then LD 0x100 -> mem_wen=0xFF at store; load resp 2 cycles later with rdata 0x1122334455667788.
REQ-038 SB 0x80 to addr 0x103, then LB 0x103 -> mem_wen=0x08, mem_wdata[31:24]=0x80; LB rdata=0xFFFFFFFFFFFFFF80; LBU rdata=0x80.
REQ-039 LW addr 0x102 -> resp_misalign=1, rdata=0, mem_wen stays 0; SH addr 0x105 -> resp_misalign=1, no write.
REQ-040 Load with resp_ready low 5 cycles -> resp_valid and resp_rdata held constant; req_ready=0 until the cycle after the resp_ready handshake.
REQ-041 Assert rst_n=0 during LOAD -> resp_valid=0 immediately; after release no response appears, req_ready=1.
REQ-042 Back-to-back SW 0xDEADBEEF to 0x104 and LWU 0x104, resp_ready high -> mem_wen=0xF0, LWU rdata=0x00000000DEADBEEF, LW rdata=0xFFFFFFFFDEADBEEF.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: pipeline-side request/response bundle for the load/store unit.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds every payload field
// stable while valid=1 and ready=0. The LSU never raises req_ready while a
// response is outstanding.
//
// Signals
//   req_valid / req_ready        request handshake (pipeline -> LSU)
//   req_we                       1 = store, 0 = load
//   req_size                     0 byte, 1 half, 2 word, 3 double
//   req_unsigned                 zero-extend load data when 1
//   req_addr                     byte address
//   req_wdata                    store data, right-justified
//   resp_valid / resp_ready      response handshake (LSU -> pipeline)
//   resp_rdata                   extended load data, 0 for stores/faults
//   resp_misalign                request was misaligned, memory untouched
//
// Modports: master = pipeline side, slave = LSU side.
interface mem_lsu_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [63:0]           req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_misalign;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_misalign
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_misalign
   );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit between the pipeline and a
// synchronous data memory (read data valid one cycle after the address is
// sampled).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   lsu             mem_lsu_if.slave request/response channel
//   mem_addr        memory address: live req_addr in IDLE, latched otherwise
//   mem_wdata       store data shifted onto its byte lanes
//   mem_wen         per-byte write enable, all zero = read
//   mem_rdata       memory read data
//   state_dbg       current FSM state (0 IDLE, 1 LOAD, 2 RESP)
module mem_lsu #(
   parameter int DATA_WIDTH = 64,
   parameter int DATA_BYTES = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mem_lsu_if.slave              lsu,
   output logic [63:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_BYTES-1:0] mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [1:0]            state_dbg
);
   localparam int OFF_W = $clog2(DATA_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [63:0]           addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [OFF_W-1:0]      off_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  misal_q;

   logic                  accept;
   logic                  misalign;
   logic [DATA_BYTES-1:0] base_mask;
   logic [DATA_BYTES-1:0] wen_mask;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_ext;

   // Alignment: low req_size address bits must be zero.
   always_comb begin
      misalign = 1'b0;
      case (lsu.req_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = lsu.req_addr[0];
         2'd2:    misalign = |lsu.req_addr[1:0];
         default: misalign = |lsu.req_addr[2:0];
      endcase
   end

   // 2^size contiguous enables, then moved up to the byte offset.
   always_comb begin
      base_mask = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < (1 << lsu.req_size)) base_mask[i] = 1'b1;
      end
   end

   assign wen_mask  = base_mask << lsu.req_addr[OFF_W-1:0];
   assign mem_wdata = lsu.req_wdata << {lsu.req_addr[OFF_W-1:0], 3'b000};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and handshake/memory-control outputs
   always_comb begin
      state_d        = state_q;
      accept         = 1'b0;
      lsu.req_ready  = 1'b0;
      lsu.resp_valid = 1'b0;
      mem_wen        = '0;
      mem_addr       = addr_q;
      case (state_q)
         S_IDLE: begin
            lsu.req_ready = 1'b1;
            mem_addr      = lsu.req_addr;
            accept        = lsu.req_valid;
            // rst_n gate keeps the memory write-protected while in reset
            if (rst_n && lsu.req_valid && lsu.req_we && !misalign)
               mem_wen = wen_mask;
            if (accept)
               state_d = (lsu.req_we || misalign) ? S_RESP : S_LOAD;
         end
         S_LOAD: state_d = S_RESP;
         S_RESP: begin
            lsu.resp_valid = 1'b1;
            if (lsu.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Load extraction from the latched offset/size/signedness
   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (size_q)
         2'd0: load_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         2'd1: load_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         2'd2: load_ext = uns_q ? {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]}
                                : {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   // Request latch and response registers. Accept clears the response so
   // stores and faults return zero; a load fills it during LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         off_q   <= '0;
         rdata_q <= '0;
         misal_q <= 1'b0;
      end else if (accept) begin
         addr_q  <= lsu.req_addr;
         size_q  <= lsu.req_size;
         uns_q   <= lsu.req_unsigned;
         off_q   <= lsu.req_addr[OFF_W-1:0];
         rdata_q <= '0;
         misal_q <= misalign;
      end else if (state_q == S_LOAD) begin
         rdata_q <= load_ext;
      end
   end

   assign lsu.resp_rdata    = rdata_q;
   assign lsu.resp_misalign = misal_q;
   assign state_dbg         = state_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu with a synchronous memory
// model and a byte-level reference memory feeding an expected queue.
module tb_mem_lsu;
   logic        clk;
   logic        rst_n;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wen;
   logic [63:0] mem_rdata;
   logic [1:0]  state_dbg;

   mem_lsu_if #(.DATA_WIDTH(64)) bus ();

   mem_lsu #(.DATA_WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lsu       (bus),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_rdata (mem_rdata),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- data memory model ----------------
   logic [63:0] dmem [256];
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++)
         if (mem_wen[i]) dmem[mem_addr[10:3]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= dmem[mem_addr[10:3]];
   end

   // ---------------- scoreboard ----------------
   logic [7:0]  ref_mem [2048];
   logic [64:0] exp_q[$];   // {misalign, rdata}
   int          total = 0;
   int          bad   = 0;
   int          accept_cyc;
   logic [7:0]  last_wen;
   logic [63:0] last_wdata;
   logic [63:0] last_rdata;

   function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                            input logic uns);
      logic [63:0] v;
      int          nb;
      v  = '0;
      nb = 1 << sz;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a[10:0] + 11'(i)];
      if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   // Entered and left at a falling edge.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] wd);
      int          n;
      logic        misal;
      logic [7:0]  exp_wen;
      logic [63:0] exp_rd;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         total++; bad++;
         $display("FAIL req_ready_timeout actual=0 required=1");
      end
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      #1;
      misal   = (a & ((64'd1 << sz) - 64'd1)) != 64'd0;
      exp_wen = (we && !misal) ? 8'(((16'd1 << (1 << sz)) - 16'd1) << a[2:0]) : 8'h00;
      last_wen   = mem_wen;
      last_wdata = mem_wdata;
      total++;
      if (mem_wen !== exp_wen) begin
         bad++;
         $display("FAIL wen addr=%h actual=%h required=%h", a, mem_wen, exp_wen);
      end
      total++;
      if (mem_addr !== a) begin
         bad++;
         $display("FAIL mem_addr_idle actual=%h required=%h", mem_addr, a);
      end
      if (we && !misal) begin
         total++;
         if (mem_wdata !== (wd << (8 * a[2:0]))) begin
            bad++;
            $display("FAIL wdata actual=%h required=%h", mem_wdata, wd << (8 * a[2:0]));
         end
      end
      if (misal) begin
         exp_rd = '0;
      end else if (we) begin
         exp_rd = '0;
         for (int i = 0; i < (1 << sz); i++) ref_mem[a[10:0] + 11'(i)] = wd[8*i +: 8];
      end else begin
         exp_rd = ref_load(a, sz, uns);
      end
      exp_q.push_back({misal, exp_rd});
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      bus.req_valid = 1'b0;
      @(negedge clk);
   endtask

   // Waits for the response (resp_ready high), compares with the queue head.
   task automatic wait_resp(input int exp_lat);
      int          n;
      int          lat;
      logic [64:0] e;
      n = 0;
      while (!bus.resp_valid && n < 10) begin
         total++;
         if (mem_wen !== 8'h00) begin
            bad++;
            $display("FAIL wen_busy actual=%h required=00", mem_wen);
         end
         @(negedge clk);
         n++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'd0;
      total++;
      if (!bus.resp_valid) begin
         bad++;
         $display("FAIL resp_timeout actual=0 required=1");
         return;
      end
      lat = cyc + 1 - accept_cyc;
      last_rdata = bus.resp_rdata;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL latency actual=%0d required=%0d", lat, exp_lat);
      end
      total++;
      if ({bus.resp_misalign, bus.resp_rdata} !== e) begin
         bad++;
         $display("FAIL resp actual=%b/%h required=%b/%h",
                  bus.resp_misalign, bus.resp_rdata, e[64], e[63:0]);
      end
      total++;
      if (bus.req_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_in_resp actual=%b required=0", bus.req_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL back_to_idle ready=%b valid=%b required=1/0",
                  bus.req_ready, bus.resp_valid);
      end
      @(negedge clk);
   endtask

   task automatic check_const(input string name, input logic [63:0] act,
                              input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd3;
      bus.req_addr  = 64'h100;
      bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(negedge clk);
      check_const("rst_state", 64'(state_dbg), 64'd0);
      check_const("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check_const("rst_rdata", bus.resp_rdata, 64'd0);
      check_const("rst_misalign", 64'(bus.resp_misalign), 64'd0);
      check_const("rst_wen", 64'(mem_wen), 64'd0);
      bus.req_valid = 1'b0;
   endtask

   task automatic test_first_accept();
      rst_n = 1'b1;
      do_req(1'b1, 2'd0, 1'b0, 64'h140, 64'h55);
      wait_resp(1);
   endtask

   task automatic test_sd_ld();
      do_req(1'b1, 2'd3, 1'b0, 64'h100, 64'h1122334455667788);
      check_const("sd_wen", 64'(last_wen), 64'hFF);
      wait_resp(1);
      do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'h0);
      wait_resp(2);
      check_const("ld_rdata", last_rdata, 64'h1122334455667788);
   endtask

   task automatic test_sb_lb();
      do_req(1'b1, 2'd0, 1'b0, 64'h103, 64'h80);
      check_const("sb_wen", 64'(last_wen), 64'h08);
      check_const("sb_wdata_lane", 64'(last_wdata[31:24]), 64'h80);
      wait_resp(1);
      do_req(1'b0, 2'd0, 1'b0, 64'h103, 64'h0);
      wait_resp(2);
      check_const("lb_rdata", last_rdata, 64'hFFFFFFFFFFFFFF80);
      do_req(1'b0, 2'd0, 1'b1, 64'h103, 64'h0);
      wait_resp(2);
      check_const("lbu_rdata", last_rdata, 64'h80);
   endtask

   task automatic test_misalign();
      do_req(1'b0, 2'd2, 1'b0, 64'h102, 64'h0);
      wait_resp(1);
      check_const("lw_mis_rdata", last_rdata, 64'h0);
      do_req(1'b1, 2'd1, 1'b0, 64'h105, 64'hAAAA);
      check_const("sh_mis_wen", 64'(last_wen), 64'h00);
      wait_resp(1);
      do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'h0);
      wait_resp(2);
      check_const("after_mis_ld", last_rdata, 64'h1122334480667788);
      do_req(1'b0, 2'd0, 1'b1, 64'h105, 64'h0);
      wait_resp(2);
   endtask

   task automatic test_backpressure();
      int          n;
      logic [64:0] e;
      logic [63:0] held;
      bus.resp_ready = 1'b0;
      do_req(1'b0, 2'd1, 1'b0, 64'h106, 64'h0);
      n = 0;
      while (!bus.resp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'd0;
      held = bus.resp_rdata;
      total++;
      if ({bus.resp_misalign, bus.resp_rdata} !== e || !bus.resp_valid) begin
         bad++;
         $display("FAIL bp_resp valid=%b actual=%h required=%h",
                  bus.resp_valid, bus.resp_rdata, e[63:0]);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== held ||
             bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h ready=%b required=1/%h/0",
                     k, bus.resp_valid, bus.resp_rdata, bus.req_ready, held);
         end
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_const("bp_release_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'h0);
      check_const("mid_load_state", 64'(state_dbg), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_const("rst_mid_valid", 64'(bus.resp_valid), 64'd0);
      check_const("rst_mid_state", 64'(state_dbg), 64'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst cycle=%0d valid=%b ready=%b required=0/1",
                     k, bus.resp_valid, bus.req_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_req(1'b1, 2'd2, 1'b0, 64'h104, 64'hDEADBEEF);
      check_const("sw_wen", 64'(last_wen), 64'hF0);
      wait_resp(1);
      do_req(1'b0, 2'd2, 1'b1, 64'h104, 64'h0);
      wait_resp(2);
      check_const("lwu_rdata", last_rdata, 64'h00000000DEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 64'h104, 64'h0);
      wait_resp(2);
      check_const("lw_rdata", last_rdata, 64'hFFFFFFFFDEADBEEF);
   endtask

   task automatic test_random();
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] a;
      logic        misal;
      for (int k = 0; k < 40; k++) begin
         we    = 1'($urandom_range(0, 1));
         sz    = 2'($urandom_range(0, 3));
         uns   = 1'($urandom_range(0, 1));
         a     = 64'h100 + 64'($urandom_range(0, 255));
         misal = (a & ((64'd1 << sz) - 64'd1)) != 64'd0;
         do_req(we, sz, uns, a, {$urandom, $urandom});
         wait_resp((we || misal) ? 1 : 2);
      end
   endtask

   // ---------------- main ----------------
   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
      rst_n            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.resp_ready   = 1'b1;
      test_reset();
      test_first_accept();
      test_sd_ld();
      test_sb_lb();
      test_misalign();
      test_backpressure();
      test_reset_mid_load();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
